// File: rtl/wb_gpio_pkg.sv
// rtl/wb_gpio_pkg.sv - register map, reset constants and helpers for the GPIO controller
package wb_gpio_pkg;

    localparam logic [2:0] REG_IN   = 3'd0;
    localparam logic [2:0] REG_OUT  = 3'd1;
    localparam logic [2:0] REG_OE   = 3'd2;
    localparam logic [2:0] REG_EN   = 3'd3;
    localparam logic [2:0] REG_POL  = 3'd4;
    localparam logic [2:0] REG_STAT = 3'd5;
    localparam logic [2:0] REG_ID   = 3'd6;

    localparam logic [31:0] POL_RST    = 32'hFFFF_FFFF;
    localparam logic [31:0] ID_DEFAULT = 32'h0A10_6910;

    // The filter counter only has to reach cycles-1; keep at least one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// rtl/gpio_debounce_bit.sv - per-pin synchroniser, debounce filter and edge pulses
module gpio_debounce_bit import wb_gpio_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic pad,
    output logic deb,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          accept;

    // Pulses mark the edge on which deb takes the new level.
    assign accept = (s2 != deb) && (cnt == CNT_LAST);
    assign rise   = accept & s2;
    assign fall   = accept & ~s2;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            deb <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= pad;
            s2 <= s1;
            if (s2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_gpio_debounce_ctrl.sv
// rtl/wb_gpio_debounce_ctrl.sv - Wishbone GPIO controller with debounced inputs and edge interrupts
module wb_gpio_debounce_ctrl import wb_gpio_pkg::*; #(
    parameter int          GPIO_WIDTH      = 4,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [31:0] ID_VALUE        = ID_DEFAULT
) (
    input  logic                  WB_CLK,
    input  logic                  WB_RST_N,
    input  logic [16:0]           WBs_ADR,
    input  logic                  WBs_CYC,
    input  logic [3:0]            WBs_BYTE_STB,
    input  logic                  WBs_WE,
    input  logic                  WBs_RD,
    input  logic                  WBs_STB,
    input  logic [31:0]           WBs_WR_DAT,
    output logic [31:0]           WBs_RD_DAT,
    output logic                  WBs_ACK,
    inout  wire  [GPIO_WIDTH-1:0] GPIO_io,
    output logic                  GPIO_Intr_o
);

    typedef logic [GPIO_WIDTH-1:0] gvec_t;

    gvec_t       out_r, oe_r, en_r, pol_r, stat_r;
    gvec_t       deb, rise, fall, int_set, w1c;
    logic        req, wr_req, rd_req;
    logic [2:0]  reg_sel;
    logic [31:0] byte_mask;
    logic [31:0] rd_mux;
    logic        unused_bus;

    assign unused_bus = ^{WBs_RD, WBs_ADR[16:5], WBs_ADR[1:0]};

    assign req       = WBs_CYC & WBs_STB & ~WBs_ACK;
    assign wr_req    = req & WBs_WE;
    assign rd_req    = req & ~WBs_WE;
    assign reg_sel   = WBs_ADR[4:2];
    assign byte_mask = {{8{WBs_BYTE_STB[3]}}, {8{WBs_BYTE_STB[2]}},
                        {8{WBs_BYTE_STB[1]}}, {8{WBs_BYTE_STB[0]}}};

    function automatic gvec_t merge(input gvec_t old, input logic [31:0] wd, input logic [31:0] m);
        return gvec_t'((32'(old) & ~m) | (wd & m));
    endfunction

    // A fresh edge event beats a same-cycle clear so no event is ever lost.
    assign int_set = (rise & pol_r) | (fall & ~pol_r);
    assign w1c     = (wr_req && reg_sel == REG_STAT) ? gvec_t'(WBs_WR_DAT & byte_mask) : '0;

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_IN:   rd_mux = 32'(deb);
            REG_OUT:  rd_mux = 32'(out_r);
            REG_OE:   rd_mux = 32'(oe_r);
            REG_EN:   rd_mux = 32'(en_r);
            REG_POL:  rd_mux = 32'(pol_r);
            REG_STAT: rd_mux = 32'(stat_r);
            REG_ID:   rd_mux = ID_VALUE;
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge WB_CLK) begin
        if (!WB_RST_N) begin
            out_r       <= '0;
            oe_r        <= '0;
            en_r        <= '0;
            pol_r       <= gvec_t'(POL_RST);
            stat_r      <= '0;
            WBs_ACK     <= 1'b0;
            WBs_RD_DAT  <= '0;
            GPIO_Intr_o <= 1'b0;
        end else begin
            WBs_ACK     <= req;
            WBs_RD_DAT  <= rd_req ? rd_mux : '0;
            GPIO_Intr_o <= |(stat_r & en_r);
            stat_r      <= (stat_r & ~w1c) | int_set;
            if (wr_req) begin
                case (reg_sel)
                    REG_OUT: out_r <= merge(out_r, WBs_WR_DAT, byte_mask);
                    REG_OE:  oe_r  <= merge(oe_r,  WBs_WR_DAT, byte_mask);
                    REG_EN:  en_r  <= merge(en_r,  WBs_WR_DAT, byte_mask);
                    REG_POL: pol_r <= merge(pol_r, WBs_WR_DAT, byte_mask);
                    default: ;
                endcase
            end
        end
    end

    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pin
        assign GPIO_io[i] = oe_r[i] ? out_r[i] : 1'bz;

        gpio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (WB_CLK),
            .resetn (WB_RST_N),
            .pad    (GPIO_io[i]),
            .deb    (deb[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

endmodule
